alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
- Time-multiplexes the single 32-bit ALU between NUM_REQ requesters, e.g. execute-stage operand path and branch/CSR address generation.
- Round-robin grant, valid/ready handshake on each request and on the shared response, one registered result slot.
- Drives the ALU's A/B/ALUop inputs and samples its combinational Out; the ALU itself stays outside this block.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- XLEN, 32, operand/result width
- OPW, 4, ALUop width
- IDW, 1, requester-id width; must equal max(1, clog2(NUM_REQ))

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; a transfer occurs when valid and ready are both high
- req_op  in  NUM_REQ*OPW  flattened ALUop per requester; slice i is [i*OPW +: OPW]
- req_a  in  NUM_REQ*XLEN  flattened operand A per requester
- req_b  in  NUM_REQ*XLEN  flattened operand B per requester
- alu_a  out  XLEN  to ALU.A
- alu_b  out  XLEN  to ALU.B
- alu_op  out  OPW  to ALU.ALUop
- alu_out  in  XLEN  from ALU.Out, combinational
- resp_valid  out  1  result slot holds a valid result
- resp_ready  in  1  consumer accepts the result
- resp_data  out  XLEN  registered ALU result
- resp_id  out  IDW  index of the requester that owns resp_data

Behaviour:
- Reset (rst_n low, asynchronous) forces:
  - resp_valid=0, resp_data=0, resp_id=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - State EMPTY; req_ready=0 while rst_n is low.
- Reset mid-operation discards any held result; no response is emitted for it.
- FSM has two states:
  - EMPTY: no result is held.
  - FULL: resp_valid=1.
- slot_free = (state==EMPTY) || resp_ready.
- Grant, combinational:
  - If slot_free, scan indices last+1, last+2, ... modulo NUM_REQ.
  - The first asserted req_valid[i] wins; req_ready[i]=1 and every other bit is 0.
  - At most one req_ready bit is high per cycle.
  - req_ready may depend combinationally on req_valid and resp_ready.
  - Requesters must hold valid, op and operands stable until granted.
- ALU drive:
  - alu_a/alu_b/alu_op = granted requester's fields.
  - With no grant they hold the last granted values, so the ALU inputs stay quiet.
- Latency: request accepted at edge N gives resp_valid=1 after edge N, carrying resp_data=alu_out and resp_id=i sampled at edge N.
- Pointer: last updates to the granted index only on a transfer.
- Transitions:
  - EMPTY, grant -> FULL.
  - EMPTY, no grant -> EMPTY.
  - FULL, resp_ready and grant -> FULL; the slot is overwritten in the same cycle, giving back-to-back throughput of 1 op/cycle.
  - FULL, resp_ready, no grant -> EMPTY.
  - FULL, !resp_ready -> FULL; resp_data/resp_id held stable and no grants issued (full back-pressure).
- Fairness: with all requesters valid continuously and resp_ready=1, grants rotate 0,1,..,NUM_REQ-1,0,...
- Starvation bound: a waiting requester waits at most NUM_REQ-1 transfers.
- Simultaneous events: a request arriving in the same cycle the slot drains is granted that cycle. No priority inversion: round-robin order only.
- alu_op is passed through unmodified; encodings are not checked here.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined, adds output grant_cnt (NUM_REQ*16, flattened) and output stall_cnt (16).
  - grant_cnt[i] increments on each transfer from requester i.
  - stall_cnt increments each cycle state==FULL && !resp_ready && |req_valid.
  - Counters saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared ALUop header (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRA, ALU_SRL, ALU_COPY_B) is used by the bench and clients.
- Arbiter-local state encodings (ST_EMPTY/ST_FULL) go in a small arbiter constants header.
- One natural sub-module: rr_pick.
  - Combinational round-robin selector.
  - Inputs: valid vector, last pointer, enable.
  - Outputs: one-hot grant and encoded index.
  - Reusable for future shared-resource arbiters.

Test Plan:
- Single request: req0 valid, ALU_ADD, A=32'h00000005, B=32'h00000003, resp_ready=1 -> req_ready[0] same cycle; next cycle resp_valid=1, resp_data=32'h00000008, resp_id=0.
- Contention: req0 ALU_SUB 10-3 and req1 ALU_XOR 32'hFF00FF00^32'h0F0F0F0F, both valid at cycle 0 after reset:
  - req0 is granted first, giving 32'h00000007/id0.
  - Then req1, giving 32'hF00FF00F/id1.
  - Then the pointer alternates on continued requests.
- Back-pressure: resp_ready=0 with a result held (ALU_SLL 1<<4 = 32'h00000010) and req1 valid -> req_ready=0 for 5 cycles, resp_data stable; on raising resp_ready, the held result drains and req1 is granted in the same cycle.
- Throughput: both requesters valid continuously for 8 cycles, resp_ready=1 -> 8 responses on consecutive cycles, ids 0,1,0,1,...
- Reset mid-operation: deassert rst_n asynchronously while resp_valid=1 -> resp_valid drops immediately, not waiting for clk. After release, req0 regains priority.
- With ALU_ARB_STATS_EN defined, after the contention and back-pressure tests -> grant_cnt values equal the exact per-requester transfer counts, and stall_cnt equals the back-pressure stall cycles (5).

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared ALU opcode encodings and the arbiter's local constants.
package alu_share_arbiter_pkg;

    // ALUop encodings shared with the bench and ALU clients
    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRA    = 4'd8,
        ALU_SRL    = 4'd9,
        ALU_COPY_B = 4'd10
    } alu_op_e;

    // Result-slot occupancy
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } arb_state_e;

    // Width of the optional statistics counters
    localparam int CNT_W = 16;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester, ALU and response bundle for the shared-ALU arbiter.
// master = requester/ALU/consumer side, slave = arbiter.
interface alu_share_arbiter_if #(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int OPW     = 4,
    parameter int IDW     = 1
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*OPW-1:0]  req_op;
    logic [NUM_REQ*XLEN-1:0] req_a;
    logic [NUM_REQ*XLEN-1:0] req_b;
    logic [XLEN-1:0]         alu_a;
    logic [XLEN-1:0]         alu_b;
    logic [OPW-1:0]          alu_op;
    logic [XLEN-1:0]         alu_out;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [XLEN-1:0]         resp_data;
    logic [IDW-1:0]          resp_id;

    modport master (
        output req_valid, req_op, req_a, req_b, alu_out, resp_ready,
        input  req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_id
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_out, resp_ready,
        output req_ready, alu_a, alu_b, alu_op, resp_valid, resp_data, resp_id
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick.sv
// Combinational round-robin selector: scans last_i+1, last_i+2, ... modulo N
// and grants the first valid index. Generic so other shared resources can
// reuse it.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] last_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);
    int j;

    // Priority scan starting just past the previous winner
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j     = 0;
        if (en_i) begin
            for (int k = 1; k <= N; k++) begin
                j = int'(last_i) + k;
                if (j >= N) j = j - N;
                for (int i = 0; i < N; i++) begin
                    if (!any_o && (i == j) && valid_i[i]) begin
                        any_o    = 1'b1;
                        gnt_o[i] = 1'b1;
                        idx_o    = IW'(i);
                    end
                end
            end
        end
    end
endmodule

// File: rtl/alu_share_arbiter.sv
// Time-multiplexes one external combinational ALU between NUM_REQ requesters
// with round-robin grant and a single registered result slot.
// Optional build macro ALU_ARB_STATS_EN adds grant_cnt/stall_cnt counters.
module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int XLEN    = 32,
    parameter int OPW     = 4,
    parameter int IDW     = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    alu_share_arbiter_if.slave       bus
`ifdef ALU_ARB_STATS_EN
    ,
    output logic [NUM_REQ*CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0]         stall_cnt
`endif
);
    arb_state_e          state_q, state_d;
    logic [IDW-1:0]      last_q, last_d;
    logic [XLEN-1:0]     resp_data_q, resp_data_d;
    logic [IDW-1:0]      resp_id_q, resp_id_d;
    logic [XLEN-1:0]     alu_a_q, alu_b_q;
    logic [OPW-1:0]      alu_op_q;

    logic                slot_free;
    logic [NUM_REQ-1:0]  gnt;
    logic [IDW-1:0]      gidx;
    logic                xfer;
    logic [XLEN-1:0]     sel_a, sel_b;
    logic [OPW-1:0]      sel_op;

    // A result can be accepted when the slot is empty or drains this cycle;
    // holding the picker off during reset keeps req_ready low.
    assign slot_free = (state_q == ST_EMPTY) || bus.resp_ready;

    rr_pick #(.N(NUM_REQ), .IW(IDW)) u_pick (
        .valid_i (bus.req_valid),
        .last_i  (last_q),
        .en_i    (slot_free & rst_n),
        .gnt_o   (gnt),
        .idx_o   (gidx),
        .any_o   (xfer)
    );

    assign bus.req_ready = gnt;

    // One-hot operand mux from the granted requester
    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_a  = bus.req_a[i*XLEN +: XLEN];
                sel_b  = bus.req_b[i*XLEN +: XLEN];
                sel_op = bus.req_op[i*OPW +: OPW];
            end
        end
    end

    // Without a grant the ALU keeps seeing the last granted operands
    assign bus.alu_a  = xfer ? sel_a  : alu_a_q;
    assign bus.alu_b  = xfer ? sel_b  : alu_b_q;
    assign bus.alu_op = xfer ? sel_op : alu_op_q;

    // Slot occupancy, pointer and result capture
    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        case (state_q)
            ST_EMPTY: if (xfer) state_d = ST_FULL;
            ST_FULL: begin
                if (xfer)                state_d = ST_FULL;
                else if (bus.resp_ready) state_d = ST_EMPTY;
            end
            default: state_d = ST_EMPTY;
        endcase
        if (xfer) begin
            last_d      = gidx;
            resp_data_d = bus.alu_out;
            resp_id_d   = gidx;
        end
    end

    // State register; reset drops any held result immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            last_q      <= IDW'(NUM_REQ - 1);
            resp_data_q <= '0;
            resp_id_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
        end
    end

    // Hold registers for the ALU inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            alu_op_q <= '0;
        end else if (xfer) begin
            alu_a_q  <= sel_a;
            alu_b_q  <= sel_b;
            alu_op_q <= sel_op;
        end
    end

    assign bus.resp_valid = (state_q == ST_FULL);
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_id    = resp_id_q;

`ifdef ALU_ARB_STATS_EN
    logic [NUM_REQ-1:0][CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0]              stall_q;

    // Saturating per-requester grant counters and back-pressure stall counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcnt_q  <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt[i] && gcnt_q[i] != {CNT_W{1'b1}})
                    gcnt_q[i] <= gcnt_q[i] + 1'b1;
            end
            if (state_q == ST_FULL && !bus.resp_ready && |bus.req_valid &&
                stall_q != {CNT_W{1'b1}})
                stall_q <= stall_q + 1'b1;
        end
    end

    assign grant_cnt = gcnt_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a transaction-level reference model.
module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int N    = 2;
    localparam int XLEN = 32;
    localparam int OPW  = 4;
    localparam int IDW  = 1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.NUM_REQ(N), .XLEN(XLEN), .OPW(OPW), .IDW(IDW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic [N*16-1:0] grant_cnt;
    logic [15:0]     stall_cnt;
`endif

    alu_share_arbiter #(.NUM_REQ(N), .XLEN(XLEN), .OPW(OPW), .IDW(IDW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ALU_ARB_STATS_EN
        ,
        .grant_cnt (grant_cnt),
        .stall_cnt (stall_cnt)
`endif
    );

    // Requester / consumer stimulus
    logic [N-1:0]    rv;
    logic [OPW-1:0]  rop [N];
    logic [XLEN-1:0] ra  [N];
    logic [XLEN-1:0] rb  [N];
    logic            rr;

    function automatic logic [XLEN-1:0] alu_f(logic [OPW-1:0] op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_ADD:    return a + b;
            ALU_SUB:    return a - b;
            ALU_AND:    return a & b;
            ALU_OR:     return a | b;
            ALU_XOR:    return a ^ b;
            ALU_SLT:    return {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU:   return {{(XLEN-1){1'b0}}, a < b};
            ALU_SLL:    return a << b[4:0];
            ALU_SRA:    return $unsigned($signed(a) >>> b[4:0]);
            ALU_SRL:    return a >> b[4:0];
            ALU_COPY_B: return b;
            default:    return '0;
        endcase
    endfunction

    always_comb begin
        bus.req_valid  = rv;
        bus.resp_ready = rr;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        for (int i = 0; i < N; i++) begin
            bus.req_op[i*OPW +: OPW]  = rop[i];
            bus.req_a[i*XLEN +: XLEN] = ra[i];
            bus.req_b[i*XLEN +: XLEN] = rb[i];
        end
    end

    // External ALU
    assign bus.alu_out = alu_f(bus.alu_op, bus.alu_a, bus.alu_b);

    // Reference model: one result slot, round-robin pointer, stats
    bit              m_full;
    logic [XLEN-1:0] m_data;
    int              m_id, m_last, m_stall;
    int              m_gcnt [N];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic m_reset();
        m_full  = 1'b0;
        m_data  = '0;
        m_id    = 0;
        m_last  = N - 1;
        m_stall = 0;
        for (int i = 0; i < N; i++) m_gcnt[i] = 0;
    endtask

    // Requester that should win this cycle, -1 when none
    function automatic int pick();
        int j;
        if (m_full && !rr) return -1;
        for (int k = 1; k <= N; k++) begin
            j = (m_last + k) % N;
            if (((rv >> j) & 1) != 0) return j;
        end
        return -1;
    endfunction

    // Check one cycle against the model, then advance through the edge
    task automatic step(output int g);
        logic [IDW-1:0] gi;
        #1;
        g  = pick();
        gi = IDW'(g);
        chk("req_ready", 64'(bus.req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
        chk("resp_valid", 64'(bus.resp_valid), 64'(m_full));
        chk("resp_data", 64'(bus.resp_data), 64'(m_data));
        chk("resp_id", 64'(bus.resp_id), 64'(m_id));
        if (g >= 0) begin
            chk("alu_a", 64'(bus.alu_a), 64'(ra[gi]));
            chk("alu_b", 64'(bus.alu_b), 64'(rb[gi]));
            chk("alu_op", 64'(bus.alu_op), 64'(rop[gi]));
        end
        @(posedge clk);
        if (m_full && !rr && rv != '0 && m_stall < 65535) m_stall++;
        if (g >= 0) begin
            m_full = 1'b1;
            m_data = alu_f(rop[gi], ra[gi], rb[gi]);
            m_id   = g;
            m_last = g;
            if (m_gcnt[gi] < 65535) m_gcnt[gi]++;
        end else if (rr) begin
            m_full = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        m_reset();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        rst_n = 1'b0;
        rr    = 1'b1;
        rv    = 2'b01;
        for (int i = 0; i < N; i++) begin
            rop[i] = '0; ra[i] = '0; rb[i] = '0;
        end
        m_reset();
        #2;
        chk("rst_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_data", 64'(bus.resp_data), 64'd0);
        chk("rst_id", 64'(bus.resp_id), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rv    = '0;
        rst_n = 1'b1;

        // Single request
        rv = 2'b01; rop[0] = ALU_ADD; ra[0] = 32'd5; rb[0] = 32'd3;
        #1 chk("single_rdy", 64'(bus.req_ready), 64'd1);
        step(g);
        rv = '0;
        chk("single_vld", 64'(bus.resp_valid), 64'd1);
        chk("single_data", 64'(bus.resp_data), 64'h8);
        chk("single_id", 64'(bus.resp_id), 64'd0);
        step(g);

        // Contention right after reset
        do_reset();
        rv = 2'b11;
        rop[0] = ALU_SUB; ra[0] = 32'd10;         rb[0] = 32'd3;
        rop[1] = ALU_XOR; ra[1] = 32'hFF00FF00;   rb[1] = 32'h0F0F0F0F;
        #1 chk("cont_rdy0", 64'(bus.req_ready), 64'b01);
        step(g);
        chk("cont_data0", 64'(bus.resp_data), 64'h7);
        chk("cont_id0", 64'(bus.resp_id), 64'd0);
        #1 chk("cont_rdy1", 64'(bus.req_ready), 64'b10);
        step(g);
        chk("cont_data1", 64'(bus.resp_data), 64'hF00FF00F);
        chk("cont_id1", 64'(bus.resp_id), 64'd1);
        step(g);
        step(g);
        rv = '0;
        step(g);

        // Back-pressure with a held result
        rv = 2'b01; rop[0] = ALU_SLL; ra[0] = 32'd1; rb[0] = 32'd4; rr = 1'b0;
        step(g);
        rv = 2'b10; rop[1] = ALU_ADD; ra[1] = 32'd2; rb[1] = 32'd3;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rdy", 64'(bus.req_ready), 64'd0);
            chk("bp_data", 64'(bus.resp_data), 64'h10);
            chk("bp_vld", 64'(bus.resp_valid), 64'd1);
            step(g);
        end
        rr = 1'b1;
        #1 chk("bp_drain_rdy", 64'(bus.req_ready), 64'b10);
        step(g);
        rv = '0;
        chk("bp_data1", 64'(bus.resp_data), 64'h5);
        chk("bp_id1", 64'(bus.resp_id), 64'd1);
        step(g);
`ifdef ALU_ARB_STATS_EN
        chk("grant_cnt0", 64'(grant_cnt[15:0]), 64'(m_gcnt[0]));
        chk("grant_cnt1", 64'(grant_cnt[31:16]), 64'(m_gcnt[1]));
        chk("stall_cnt", 64'(stall_cnt), 64'd5);
        chk("stall_model", 64'(stall_cnt), 64'(m_stall));
`endif

        // Throughput: one response per cycle, alternating ids
        rv = 2'b11; rr = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(g);
            chk("tp_vld", 64'(bus.resp_valid), 64'd1);
            chk("tp_id", 64'(bus.resp_id), 64'(k % 2));
        end
        rv = '0;
        step(g);

        // Asynchronous reset while holding a result
        rv = 2'b01; rop[0] = ALU_OR; ra[0] = 32'hA0; rb[0] = 32'h0B; rr = 1'b0;
        step(g);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", 64'(bus.resp_valid), 64'd0);
        chk("arst_rdy", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        rv = 2'b11; rr = 1'b1;
        #1 chk("arst_prio", 64'(bus.req_ready), 64'b01);
        step(g);
        rv = '0;
        step(g);

        // Random traffic; pending requests stay stable until granted
        for (int c = 0; c < 400; c++) begin
            rr = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (!(rv[IDW'(i)] && g != i && g != -2)) begin
                    rv[IDW'(i)]  = 1'($urandom_range(0, 1));
                    rop[IDW'(i)] = OPW'($urandom_range(0, 10));
                    ra[IDW'(i)]  = $urandom;
                    rb[IDW'(i)]  = $urandom;
                end
            end
            step(g);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
